jtag_ping_pong_buffer: RTL
==========================

JTAG_PING_PONG_BUFFER -- requirements
Module: jtag_ping_pong_buffer

Interface
REQ-001 SHALL have parameter BANK_WORDS, default 256, meaning words per bank; fixed at 256 in this revision.
REQ-002 SHALL have port clock  in  1  single system clock; all logic on rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port jtag_address  in  8  JTAG-side word offset into the JTAG-owned bank.
REQ-005 SHALL have port jtag_dataIn  in  32  JTAG-side write data.
REQ-006 SHALL have port jtag_writeEnable  in  1  JTAG-side write strobe.
REQ-007 SHALL have port jtag_dataOut  out  32  JTAG-side read data, registered.
REQ-008 SHALL have port jtag_swap_request  in  1  single-cycle pulse: JTAG bank complete, hand it to the DMA.
REQ-009 SHALL have port jtag_block_sizeIN  in  8  word count of the handed-over bank, sampled with jtag_swap_request.
REQ-010 SHALL have port jtag_block_sizeOUT  out  8  word count returned by the DMA in the bank now owned by JTAG.
REQ-011 SHALL have port jtag_swap_pending  out  1  JTAG request latched, swap not yet done.
REQ-012 SHALL have port pp_address  in  9  DMA-side word address; bits [7:0] used, bit 8 ignored.
REQ-013 SHALL have port pp_dataIn  in  32  DMA-side write data.
REQ-014 SHALL have port pp_writeEnable  in  1  DMA-side write strobe.
REQ-015 SHALL have port pp_dataOut  out  32  DMA-side read data, registered.
REQ-016 SHALL have port dma_done  in  1  single-cycle pulse: DMA finished with its bank.
REQ-017 SHALL have port dma_block_sizeIN  in  8  word count the DMA leaves in its bank, sampled with dma_done.
REQ-018 SHALL have port dma_block_sizeOUT  out  8  word count of the bank now owned by the DMA.
REQ-019 SHALL have port dma_block_ready  out  1  DMA bank holds a fresh block; high from swap until dma_done.
REQ-020 SHALL have port bank_select  out  1  physical bank owned by JTAG; DMA owns ~bank_select.
REQ-021 SHALL have port swap_count  out  16  number of completed swaps.

Function
REQ-022 SHALL map JTAG port to physical address {bank_select, jtag_address} and DMA port to {~bank_select, pp_address[7:0]}.
REQ-023 SHALL perform a write on the edge where the write enable is high; both ports may write in the same cycle, and they never collide (different banks).
REQ-024 SHALL return read data one cycle after the address, from the bank owned at address time; a read issued on the swap edge returns old-bank data.
REQ-025 SHALL latch jtag_swap_request into jtag_swap_pending and capture jtag_block_sizeIN at that edge; further requests while pending are ignored, and the first size is kept.
REQ-026 SHALL latch dma_done into an internal dma_idle flag and capture dma_block_sizeIN; dma_done while dma_block_ready=0 is ignored.
REQ-027 SHALL swap on the first edge where (jtag request or pending) AND (dma_done or dma_idle), including simultaneous pulses: toggle bank_select, dma_block_sizeOUT<=JTAG size, jtag_block_sizeOUT<=DMA size, dma_block_ready<=1, clear pending and idle flags, and increment swap_count (wraps 0xFFFF->0).
REQ-028 SHALL otherwise leave all outputs stable; JTAG writes during pending remain in the JTAG-owned bank.
REQ-029 SHALL clear dma_block_ready on the edge dma_done is sampled.

Reset
REQ-030 SHALL, when reset is high at an edge, set bank_select=0, jtag_swap_pending=0, dma_idle=1, dma_block_ready=0, both block-size outputs=0, swap_count=0, jtag_dataOut=0, pp_dataOut=0; memory contents are not cleared.
REQ-031 SHALL let reset override any simultaneous request, done or write, and abort a pending swap.

Structure
REQ-032 SHALL place BANK_WORDS, the address width (8) and the data width (32) in the shared package jtag_pkg.
REQ-033 SHALL implement storage as one sub-module dual_port_ram_512x32 (two registered read/write ports, no reset).

Verification
REQ-034 SHALL cover: reset, then jtag_swap_request with size 19 -> next cycle bank_select=1, dma_block_sizeOUT=19, dma_block_ready=1, swap_count=1.
REQ-035 SHALL cover: JTAG writes 0xA0000000+i to offsets 0..18, then swap, then DMA reads pp_address 0..18 -> pp_dataOut = 0xA0000000+i, one cycle later.
REQ-036 SHALL cover: request while dma_block_ready=1 -> jtag_swap_pending=1 and no swap; dma_done with size 10 after 10 cycles -> swap on that edge, jtag_block_sizeOUT=10.
REQ-037 SHALL cover: jtag_swap_request and dma_done in the same cycle -> exactly one swap, swap_count+1.
REQ-038 SHALL cover: reset asserted while pending -> all outputs at reset values the next cycle and no swap.
REQ-039 SHALL cover: pp_address=0x105 with bit 8 set -> the same word as 0x005.

Source files
------------

// File: rtl/jtag_pkg.sv
// rtl/jtag_pkg.sv - shared widths and bank geometry for the JTAG ping-pong buffer
package jtag_pkg;
    localparam int BANK_WORDS = 256;
    localparam int ADDR_W     = 8;
    localparam int DATA_W     = 32;
    localparam int SIZE_W     = 8;
    localparam int COUNT_W    = 16;
    localparam int RAM_ADDR_W = ADDR_W + 1;
endpackage

// File: rtl/dual_port_ram_512x32.sv
// rtl/dual_port_ram_512x32.sv - true dual-port RAM, registered read-first ports, no reset
module dual_port_ram_512x32
    import jtag_pkg::*;
#(
    parameter int DEPTH = 2 * BANK_WORDS
) (
    input  logic                  i_clk,
    input  logic [RAM_ADDR_W-1:0] i_a_addr,
    input  logic [DATA_W-1:0]     i_a_wdata,
    input  logic                  i_a_we,
    output logic [DATA_W-1:0]     o_a_rdata,
    input  logic [RAM_ADDR_W-1:0] i_b_addr,
    input  logic [DATA_W-1:0]     i_b_wdata,
    input  logic                  i_b_we,
    output logic [DATA_W-1:0]     o_b_rdata
);
    logic [DATA_W-1:0] r_mem [0:DEPTH-1];
    logic [DATA_W-1:0] r_a_rdata;
    logic [DATA_W-1:0] r_b_rdata;

    // Both ports share one process so the array has a single driver.
    always_ff @(posedge i_clk) begin
        r_a_rdata <= r_mem[i_a_addr];
        r_b_rdata <= r_mem[i_b_addr];
        if (i_a_we) r_mem[i_a_addr] <= i_a_wdata;
        if (i_b_we) r_mem[i_b_addr] <= i_b_wdata;
    end

    assign o_a_rdata = r_a_rdata;
    assign o_b_rdata = r_b_rdata;
endmodule

// File: rtl/jtag_ping_pong_buffer.sv
// rtl/jtag_ping_pong_buffer.sv - two-bank buffer swapped between a JTAG side and a DMA side
module jtag_ping_pong_buffer #(
    parameter int BANK_WORDS = jtag_pkg::BANK_WORDS
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [jtag_pkg::ADDR_W-1:0]  jtag_address,
    input  logic [jtag_pkg::DATA_W-1:0]  jtag_dataIn,
    input  logic                         jtag_writeEnable,
    output logic [jtag_pkg::DATA_W-1:0]  jtag_dataOut,
    input  logic                         jtag_swap_request,
    input  logic [jtag_pkg::SIZE_W-1:0]  jtag_block_sizeIN,
    output logic [jtag_pkg::SIZE_W-1:0]  jtag_block_sizeOUT,
    output logic                         jtag_swap_pending,
    input  logic [jtag_pkg::ADDR_W:0]    pp_address,
    input  logic [jtag_pkg::DATA_W-1:0]  pp_dataIn,
    input  logic                         pp_writeEnable,
    output logic [jtag_pkg::DATA_W-1:0]  pp_dataOut,
    input  logic                         dma_done,
    input  logic [jtag_pkg::SIZE_W-1:0]  dma_block_sizeIN,
    output logic [jtag_pkg::SIZE_W-1:0]  dma_block_sizeOUT,
    output logic                         dma_block_ready,
    output logic                         bank_select,
    output logic [jtag_pkg::COUNT_W-1:0] swap_count
);
    import jtag_pkg::*;

    logic                  r_bank_select;
    logic                  r_pending;
    logic                  r_dma_idle;
    logic                  r_dma_ready;
    logic                  r_dout_zero;
    logic [SIZE_W-1:0]     r_jtag_size;
    logic [SIZE_W-1:0]     r_dma_size;
    logic [SIZE_W-1:0]     r_dma_size_out;
    logic [SIZE_W-1:0]     r_jtag_size_out;
    logic [COUNT_W-1:0]    r_swap_count;

    logic                  w_dma_done_ok;
    logic                  w_jtag_want;
    logic                  w_dma_free;
    logic                  w_swap;
    logic [SIZE_W-1:0]     w_jtag_size_eff;
    logic [SIZE_W-1:0]     w_dma_size_eff;
    logic [RAM_ADDR_W-1:0] w_jtag_addr;
    logic [RAM_ADDR_W-1:0] w_dma_addr;
    logic [DATA_W-1:0]     w_jtag_q;
    logic [DATA_W-1:0]     w_dma_q;
    logic                  w_unused_addr_msb;

    assign w_unused_addr_msb = pp_address[ADDR_W];

    assign w_jtag_addr = {r_bank_select, jtag_address};
    assign w_dma_addr  = {~r_bank_select, pp_address[ADDR_W-1:0]};

    // A done pulse only counts while the DMA actually holds a block.
    assign w_dma_done_ok   = dma_done & r_dma_ready;
    assign w_jtag_want     = jtag_swap_request | r_pending;
    assign w_dma_free      = w_dma_done_ok | r_dma_idle;
    assign w_swap          = w_jtag_want & w_dma_free;
    assign w_jtag_size_eff = r_pending ? r_jtag_size : jtag_block_sizeIN;
    assign w_dma_size_eff  = w_dma_done_ok ? dma_block_sizeIN : r_dma_size;

    dual_port_ram_512x32 #(
        .DEPTH (2 * BANK_WORDS)
    ) u_ram (
        .i_clk     (clock),
        .i_a_addr  (w_jtag_addr),
        .i_a_wdata (jtag_dataIn),
        .i_a_we    (jtag_writeEnable & ~reset),
        .o_a_rdata (w_jtag_q),
        .i_b_addr  (w_dma_addr),
        .i_b_wdata (pp_dataIn),
        .i_b_we    (pp_writeEnable & ~reset),
        .o_b_rdata (w_dma_q)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_bank_select   <= 1'b0;
            r_pending       <= 1'b0;
            r_dma_idle      <= 1'b1;
            r_dma_ready     <= 1'b0;
            r_dout_zero     <= 1'b1;
            r_jtag_size     <= '0;
            r_dma_size      <= '0;
            r_dma_size_out  <= '0;
            r_jtag_size_out <= '0;
            r_swap_count    <= '0;
        end else begin
            r_dout_zero <= 1'b0;
            if (w_swap) begin
                r_bank_select   <= ~r_bank_select;
                r_dma_size_out  <= w_jtag_size_eff;
                r_jtag_size_out <= w_dma_size_eff;
                r_dma_ready     <= 1'b1;
                r_pending       <= 1'b0;
                r_dma_idle      <= 1'b0;
                r_swap_count    <= r_swap_count + 1'b1;
            end else begin
                if (jtag_swap_request && !r_pending) begin
                    r_pending   <= 1'b1;
                    r_jtag_size <= jtag_block_sizeIN;
                end
                if (w_dma_done_ok) begin
                    r_dma_idle  <= 1'b1;
                    r_dma_size  <= dma_block_sizeIN;
                    r_dma_ready <= 1'b0;
                end
            end
        end
    end

    // RAM ports carry no reset, so the read data is masked for the cycle after reset.
    assign jtag_dataOut       = r_dout_zero ? '0 : w_jtag_q;
    assign pp_dataOut         = r_dout_zero ? '0 : w_dma_q;
    assign jtag_block_sizeOUT = r_jtag_size_out;
    assign jtag_swap_pending  = r_pending;
    assign dma_block_sizeOUT  = r_dma_size_out;
    assign dma_block_ready    = r_dma_ready;
    assign bank_select        = r_bank_select;
    assign swap_count         = r_swap_count;
endmodule
